// File: rtl/xor_descrambler8.sv
// Byte-stream XOR descrambler: each accepted byte is XORed with an 8-bit Galois LFSR keystream.
// Frames are bounded by a programmed byte count. The output is a single-entry registered stage.
module xor_descrambler8 #(
  parameter logic [7:0] POLY = 8'hB8,
  parameter logic [7:0] SEED = 8'hFF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       seed_load,
  input  logic [7:0] seed_in,
  input  logic       frame_start,
  input  logic [7:0] frame_len,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       busy,
  output logic       frame_done
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t     state, state_nxt;
  logic [7:0] seed_q, lfsr, lfsr_nxt, seed_fix, seed_eff;
  logic [8:0] cnt;
  logic       accept, last;

  // A zero seed would lock the LFSR at zero, so it is replaced by SEED.
  assign seed_fix = (seed_in == 8'h00) ? SEED : seed_in;
  assign seed_eff = seed_load ? seed_fix : seed_q;
  assign lfsr_nxt = {1'b0, lfsr[7:1]} ^ (lfsr[0] ? POLY : 8'h00);

  assign in_ready = (state == RUN) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign last     = accept && (cnt == 9'd1);
  assign busy     = (state == RUN);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (frame_start) state_nxt = RUN;
      RUN:     if (last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          seed_q <= SEED;
    else if (state == IDLE && seed_load) seed_q <= seed_fix;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= SEED;
      cnt  <= 9'd0;
    end else if (state == IDLE && frame_start) begin
      lfsr <= seed_eff;
      cnt  <= (frame_len == 8'h00) ? 9'd256 : {1'b0, frame_len};
    end else if (accept) begin
      lfsr <= lfsr_nxt;
      cnt  <= cnt - 9'd1;
    end
  end

  // A drain and a new accept in the same cycle keep out_valid high with the new byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= 8'h00;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= in_data ^ lfsr;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frame_done <= 1'b0;
    else        frame_done <= last;
  end

endmodule

// File: tb/tb_xor_descrambler8.sv
// Scoreboard bench for xor_descrambler8: expected bytes are queued on accept, popped on output.
module tb_xor_descrambler8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       seed_load = 1'b0;
  logic [7:0] seed_in = 8'h00;
  logic       frame_start = 1'b0;
  logic [7:0] frame_len = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'h00;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_data;
  logic       busy;
  logic       frame_done;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         n_out = 0;
  logic [7:0] sb[$];
  logic [7:0] mseed = 8'hFF;
  logic [7:0] mlfsr = 8'hFF;

  xor_descrambler8 dut (
    .clk(clk), .rst_n(rst_n), .seed_load(seed_load), .seed_in(seed_in),
    .frame_start(frame_start), .frame_len(frame_len), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] step(input logic [7:0] s);
    return {1'b0, s[7:1]} ^ (s[0] ? 8'hB8 : 8'h00);
  endfunction

  // Output monitor: every handshake pops one expected byte.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      n_out++;
      if (sb.size() == 0) chk("extra_out", 1, 0);
      else                chk("out_data", out_data, sb.pop_front());
    end
  end

  task automatic start(input logic [7:0] len, input logic ld, input logic [7:0] sd);
    frame_start = 1'b1; frame_len = len; seed_load = ld; seed_in = sd;
    if (ld) mseed = (sd == 8'h00) ? 8'hFF : sd;
    mlfsr = mseed;
    @(posedge clk); #1;
    frame_start = 1'b0; seed_load = 1'b0;
    chk("busy_start", busy, 1);
  endtask

  // Holds in_valid until the byte is accepted; leaves in_valid high for back-to-back use.
  task automatic send(input logic [7:0] d, input logic [7:0] e);
    bit acc = 0;
    in_valid = 1'b1; in_data = d;
    for (int t = 0; t < 64 && !acc; t++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(e);
        mlfsr = step(mlfsr);
        acc = 1;
      end
      @(posedge clk); #1;
    end
    if (!acc) chk("accept_timeout", 0, 1);
  endtask

  task automatic end_check();
    chk("frame_done_hi", frame_done, 1);
    chk("busy_end", busy, 0);
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("frame_done_lo", frame_done, 0);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", sb.size(), 0);
  endtask

  initial begin
    logic [7:0] ks_tbl[5];
    logic [7:0] pt[4];
    logic [7:0] d;
    int c0, n0;
    ks_tbl = '{8'hFF, 8'hC7, 8'hDB, 8'hD5, 8'hD2};
    pt = '{8'h01, 8'h02, 8'h03, 8'h04};

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_frame_done", frame_done, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // known keystream, full throughput
    start(8'd5, 1'b0, 8'h00);
    c0 = cyc;
    for (int i = 0; i < 5; i++) begin
      send(8'h00, ks_tbl[i]);
      if (i < 4) chk("frame_done_early", frame_done, 0);
    end
    chk("throughput_cycles", cyc - c0, 5);
    end_check();
    drain();

    // backpressure: out_ready low for 4 cycles after first byte
    n0 = n_out;
    start(8'd3, 1'b0, 8'h00);
    send(8'h00, 8'hFF);
    out_ready = 1'b0;
    in_data = 8'h00;
    repeat (4) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_out_data", out_data, 8'hFF);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    send(8'h00, 8'hC7);
    send(8'h00, 8'hDB);
    end_check();
    drain();
    chk("bp_count", n_out - n0, 3);

    // zero seed and zero length: 256 bytes
    seed_load = 1'b1; seed_in = 8'h00;
    @(posedge clk); #1;
    seed_load = 1'b0;
    n0 = n_out;
    start(8'd0, 1'b0, 8'h00);
    send(8'h00, 8'hFF);
    send(8'h00, 8'hC7);
    for (int i = 2; i < 256; i++) begin
      d = 8'($urandom);
      send(d, d ^ mlfsr);
      if (i == 254) begin
        chk("len256_busy", busy, 1);
        chk("len256_done_early", frame_done, 0);
      end
    end
    end_check();
    drain();
    chk("len256_count", n_out - n0, 256);

    // round trip with seed 5A (scrambler keystream computed by the bench)
    start(8'd4, 1'b1, 8'h5A);
    for (int i = 0; i < 4; i++) send(pt[i] ^ mlfsr, pt[i]);
    end_check();
    drain();

    // ignored controls during RUN
    n0 = n_out;
    start(8'd5, 1'b0, 8'h00);
    send(8'h11, 8'h11 ^ mlfsr);
    send(8'h22, 8'h22 ^ mlfsr);
    in_valid = 1'b0;
    seed_load = 1'b1; seed_in = 8'h33; frame_start = 1'b1; frame_len = 8'd1;
    @(posedge clk); #1;
    seed_load = 1'b0; frame_start = 1'b0;
    chk("ign_busy", busy, 1);
    send(8'h33, 8'h33 ^ mlfsr);
    send(8'h44, 8'h44 ^ mlfsr);
    chk("ign_busy_mid", busy, 1);
    send(8'h55, 8'h55 ^ mlfsr);
    end_check();
    drain();
    chk("ign_count", n_out - n0, 5);
    // seed register must still hold 5A
    start(8'd1, 1'b0, 8'h00);
    send(8'h00, 8'h5A);
    end_check();
    drain();

    // reset mid-frame with a pending byte
    start(8'd5, 1'b0, 8'h00);
    send(8'h00, 8'h00 ^ mlfsr);
    send(8'h00, 8'h00 ^ mlfsr);
    in_valid = 1'b0;
    out_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    sb.delete();
    mseed = 8'hFF;
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    start(8'd2, 1'b0, 8'h00);
    send(8'h00, 8'hFF);
    send(8'h00, 8'hC7);
    end_check();
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/xor_descrambler8.md
# xor_descrambler8

Byte-stream descrambler for the ALU datapath's XOR scrambling path. Each byte of a scrambled frame is XORed with an 8-bit Galois LFSR keystream. The keystream is seeded identically to the transmit-side scrambler, so applying the same operation recovers the plaintext. The block sits between the link receive buffer (upstream, valid/ready) and the ALU operand path (downstream, valid/ready), and frames are bounded by a programmed byte count.

## Interface

Parameters:
- POLY, 8'hB8, Galois feedback mask (x^8+x^6+x^5+x^4+1).
- SEED, 8'hFF, reset and default seed; also substituted whenever a zero seed is loaded.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  asynchronous, active-low reset.
- seed_load  input  1  load seed_in into the seed register (IDLE only).
- seed_in  input  8  new seed; 8'h00 is replaced by SEED.
- frame_start  input  1  start a frame (IDLE only).
- frame_len  input  8  bytes in the frame; 0 means 256.
- in_valid  input  1  upstream byte valid.
- in_ready  output  1  block accepts a byte this cycle.
- in_data  input  8  scrambled byte.
- out_valid  output  1  descrambled byte valid.
- out_ready  input  1  downstream accepts.
- out_data  output  8  descrambled byte.
- busy  output  1  high while state is RUN.
- frame_done  output  1  one-cycle pulse after the last byte of a frame is accepted.

## Operation

- States: IDLE, RUN.
  - IDLE -> RUN when frame_start=1. The LFSR loads from the seed register and the counter loads frame_len; 0 loads 256.
  - RUN -> IDLE at the edge that accepts the last byte (counter reaches 1).
- seed_load=1 in IDLE writes the seed register. If seed_load and frame_start are both high in the same IDLE cycle, the new seed is used for that frame.
- seed_load and frame_start are ignored in RUN.
- Handshakes:
  - in_ready = (state==RUN) && (!out_valid || out_ready).
  - A byte is accepted when in_valid && in_ready.
- On accept:
  - out_data <= in_data ^ lfsr; out_valid <= 1.
  - lfsr <= (lfsr >> 1) ^ (lfsr[0] ? POLY : 8'h00).
  - counter decrements.
- out_valid clears on out_valid && out_ready with no new accept in the same cycle. If both happen in the same cycle, out_valid stays 1 and out_data carries the new byte.
- out_data holds stable while out_valid=1 and out_ready=0.
- The LFSR never reaches zero: the seed is nonzero and POLY is maximal length. The keystream period is 255.
- Reset values: state=IDLE, seed register=SEED, lfsr=SEED, counter=0, in_ready=0, out_valid=0, out_data=8'h00, busy=0, frame_done=0.
- Reset mid-frame aborts the frame. All outputs and registers go to their reset values asynchronously, and any pending out byte is discarded.

## Timing

- frame_start sampled at edge k: busy=1 and in_ready may rise after edge k.
- Latency is one cycle. A byte accepted at edge n shows out_valid/out_data after edge n.
- Throughput is one byte per cycle when out_ready=1 continuously.
- frame_done is registered high after the last-accept edge for exactly one cycle. busy drops at that same edge.
- The last out byte may remain pending after the return to IDLE. A new frame_start in IDLE is legal then, but in_ready stays 0 until the pending byte drains.

## Test plan

- Known keystream: after reset, frame_start with frame_len=5, and in_data 00,00,00,00,00 with out_ready=1 -> out_data FF,C7,DB,D5,D2 on consecutive cycles. frame_done pulses once, and busy falls with the last accept.
- Round trip: seed_load with seed_in=8'h5A, then frame_len=4 with the scrambler's output for plaintext 01,02,03,04 -> out_data 01,02,03,04.
- Backpressure: frame_len=3 with out_ready=0 for 4 cycles after the first byte -> in_ready=0, out_data held at FF (input 00), and no byte lost or duplicated once out_ready=1.
- Zero seed and length: seed_in=8'h00 loaded, frame_len=0 -> the keystream starts FF,C7 and exactly 256 bytes are accepted before frame_done.
- Ignored controls: seed_load=1 and frame_start=1 pulsed during RUN -> no change to the keystream or the counter.
- Reset mid-frame: rst_n low for 1 cycle after 2 of 5 bytes -> out_valid=0, busy=0, in_ready=0 immediately. A new frame restarts the keystream at FF.
